// File: rtl/lsu_pkg.sv
// rtl/lsu_pkg.sv - shared types, constants and helpers for the load/store unit
//
// Contents:
//   F3_*             RV32 load/store width codes (funct3)
//   lsu_state_t      controller state encoding
//   lsu_extend       sign/zero extension of right-aligned load data
//   lsu_misaligned   alignment and funct3 legality check at accept
package lsu_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LD     = 3'd1,
    CAP    = 3'd2,
    RMW_RD = 3'd3,
    MERGE  = 3'd4,
    WR     = 3'd5,
    RESP   = 3'd6
  } lsu_state_t;

  // emu_ram has already shifted the addressed lane down to bit 0.
  function automatic logic [31:0] lsu_extend(input logic [2:0] funct3, input logic [31:0] q);
    logic [31:0] r;
    case (funct3)
      F3_B:    r = {{24{q[7]}}, q[7:0]};
      F3_BU:   r = {24'h0, q[7:0]};
      F3_H:    r = {{16{q[15]}}, q[15:0]};
      F3_HU:   r = {16'h0, q[15:0]};
      default: r = q;
    endcase
    return r;
  endfunction

  // Returns 1 for anything that must not touch memory: misaligned halves
  // and words, reserved funct3 codes, and unsigned widths on stores.
  function automatic logic lsu_misaligned(input logic [2:0] funct3, input logic [1:0] addr,
                                          input logic we);
    logic bad;
    case (funct3)
      F3_B:    bad = 1'b0;
      F3_H:    bad = addr[0];
      F3_W:    bad = (addr != 2'b00);
      F3_BU:   bad = we;
      F3_HU:   bad = we | addr[0];
      default: bad = 1'b1;
    endcase
    return bad;
  endfunction

endpackage

// File: rtl/lsu_store_merge.sv
// rtl/lsu_store_merge.sv - combinational byte/half lane merge for sub-word stores
//
// Ports:
//   old_word  in  32  word read back from memory
//   wdata     in  16  right-aligned store data (only low byte used for sb)
//   funct3    in   3  F3_H replaces a half, anything else replaces a byte
//   offset    in   2  byte offset of the store within the word
//   merged    out 32  old_word with the addressed lane(s) replaced
module lsu_store_merge
  import lsu_pkg::*;
(
  input  logic [31:0] old_word,
  input  logic [15:0] wdata,
  input  logic [2:0]  funct3,
  input  logic [1:0]  offset,
  output logic [31:0] merged
);

  always_comb begin
    merged = old_word;
    if (funct3 == F3_H) begin
      if (offset[1]) merged[31:16] = wdata;
      else           merged[15:0]  = wdata;
    end else begin
      merged[{offset, 3'b000} +: 8] = wdata[7:0];
    end
  end

endmodule

// File: rtl/lsu_mem_ctrl.sv
// rtl/lsu_mem_ctrl.sv - load/store controller between the memory stage and emu_ram
//
// Optional feature macro: LSU_RMW_EN (read-modify-write for sb/sh).
//
// Ports:
//   clk, rstn                        clock, asynchronous active-low reset
//   req_valid/req_ready              request handshake (ready only in IDLE)
//   req_we, req_funct3, req_addr,    request: store flag, width code, byte
//   req_wdata                        address, right-aligned store data
//   resp_valid/resp_ready            response handshake
//   resp_rdata, resp_err             extended load data, error flag
//   mem_rwtyp, mem_addr, mem_data,   emu_ram control/address/data pins
//   mem_wren, mem_rden
//   mem_q                            emu_ram read data, one clock after mem_rden
module lsu_mem_ctrl
  import lsu_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic [2:0]            req_funct3,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  output logic                  resp_valid,
  input  logic                  resp_ready,
  output logic [DATA_WIDTH-1:0] resp_rdata,
  output logic                  resp_err,
  output logic [2:0]            mem_rwtyp,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_data,
  output logic                  mem_wren,
  output logic                  mem_rden,
  input  logic [DATA_WIDTH-1:0] mem_q
);

  lsu_state_t            state_q, state_d;
  logic [2:0]            f3_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [DATA_WIDTH-1:0] wdata_q;
  logic [DATA_WIDTH-1:0] rdata_q;
  logic                  err_q;
  logic                  accept;
  logic                  accept_err;
  logic [ADDR_WIDTH-1:0] addr_word;

  assign accept     = (state_q == IDLE) && req_valid;
  assign accept_err = lsu_misaligned(req_funct3, req_addr[1:0], req_we);
  assign addr_word  = {addr_q[ADDR_WIDTH-1:2], 2'b00};

`ifdef LSU_RMW_EN
  logic [DATA_WIDTH-1:0] merge_q;
  logic [DATA_WIDTH-1:0] merged;

  lsu_store_merge u_merge (
    .old_word (mem_q),
    .wdata    (wdata_q[15:0]),
    .funct3   (f3_q),
    .offset   (addr_q[1:0]),
    .merged   (merged)
  );
`endif

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d    = state_q;
    req_ready  = 1'b0;
    resp_valid = 1'b0;
    mem_rwtyp  = 3'b000;
    mem_addr   = '0;
    mem_data   = '0;
    mem_wren   = 1'b0;
    mem_rden   = 1'b0;
    case (state_q)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          if (accept_err)              state_d = RESP;
          else if (!req_we)            state_d = LD;
          else if (req_funct3 == F3_W) state_d = WR;
`ifdef LSU_RMW_EN
          else                         state_d = RMW_RD;
`else
          else                         state_d = WR;
`endif
        end
      end
      LD: begin
        mem_rden  = 1'b1;
        mem_rwtyp = f3_q;
        mem_addr  = addr_q;
        state_d   = CAP;
      end
      CAP: state_d = RESP;
`ifdef LSU_RMW_EN
      RMW_RD: begin
        mem_rden  = 1'b1;
        mem_rwtyp = F3_W;
        mem_addr  = addr_word;
        state_d   = MERGE;
      end
      MERGE: state_d = WR;
      WR: begin
        mem_wren  = 1'b1;
        mem_rwtyp = F3_W;
        mem_addr  = addr_word;
        mem_data  = (f3_q == F3_W) ? wdata_q : merge_q;
        state_d   = RESP;
      end
`else
      // Sub-word stores rely on emu_ram's native write, which replaces the whole word.
      WR: begin
        mem_wren  = 1'b1;
        mem_rwtyp = f3_q;
        mem_addr  = addr_q;
        mem_data  = wdata_q;
        state_d   = RESP;
      end
`endif
      RESP: begin
        resp_valid = 1'b1;
        if (resp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      f3_q    <= 3'b000;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else if (accept) begin
      f3_q    <= req_funct3;
      addr_q  <= req_addr;
      wdata_q <= req_wdata;
      rdata_q <= '0;
      err_q   <= accept_err;
    end else if (state_q == CAP) begin
      rdata_q <= lsu_extend(f3_q, mem_q);
    end
  end

`ifdef LSU_RMW_EN
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn)                 merge_q <= '0;
    else if (state_q == MERGE) merge_q <= merged;
  end
`endif

  assign resp_rdata = rdata_q;
  assign resp_err   = err_q;

endmodule

// File: tb/tb_lsu_mem_ctrl.sv
// tb/tb_lsu_mem_ctrl.sv - directed self-checking bench for lsu_mem_ctrl with an emu_ram model
module tb_lsu_mem_ctrl;

  logic        clk;
  logic        rstn;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic        resp_ready;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic [2:0]  mem_rwtyp;
  logic [31:0] mem_addr;
  logic [31:0] mem_data;
  logic        mem_wren;
  logic        mem_rden;
  logic [31:0] mem_q;

  int n_cmp = 0;
  int n_bad = 0;
  int rden_cnt = 0;
  int wren_cnt = 0;
  int both_cnt = 0;

  logic [31:0] rd;
  logic        er;
  int          lat;
  logic [31:0] word_exp;

  logic [31:0] mem [0:255];

  lsu_mem_ctrl #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) dut (
    .clk        (clk),
    .rstn       (rstn),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_we     (req_we),
    .req_funct3 (req_funct3),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_rdata (resp_rdata),
    .resp_err   (resp_err),
    .mem_rwtyp  (mem_rwtyp),
    .mem_addr   (mem_addr),
    .mem_data   (mem_data),
    .mem_wren   (mem_wren),
    .mem_rden   (mem_rden),
    .mem_q      (mem_q)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // emu_ram model: native writes replace the whole word; sub-word reads are shifted down.
  always @(posedge clk) begin
    if (mem_wren) mem[mem_addr[9:2]] <= mem_data;
    if (mem_rden) begin
      if (mem_rwtyp[1:0] == 2'b10) mem_q <= mem[mem_addr[9:2]];
      else                         mem_q <= mem[mem_addr[9:2]] >> {mem_addr[1:0], 3'b000};
    end
  end

  always @(negedge clk) begin
    if (mem_rden) rden_cnt++;
    if (mem_wren) wren_cnt++;
    if (mem_rden && mem_wren) both_cnt++;
  end

  task automatic wait_ready();
    int w;
    w = 0;
    while (!req_ready && w < 20) begin
      @(posedge clk); #1; w++;
    end
    if (!req_ready) begin
      n_cmp++; n_bad++;
      $display("FAIL req_ready_timeout: req_ready=%0b required 1", req_ready);
    end
  endtask

  task automatic wait_resp(output int l);
    l = 0;
    while (!resp_valid && l < 20) begin
      @(posedge clk); #1; l++;
    end
    if (!resp_valid) begin
      n_cmp++; n_bad++;
      $display("FAIL resp_valid_timeout: resp_valid=%0b required 1", resp_valid);
    end
  endtask

  // Issues one request with resp_ready=1; returns response fields and edges from accept to resp_valid.
  task automatic do_req(input logic we, input logic [2:0] f3, input logic [31:0] a,
                        input logic [31:0] wd, output logic [31:0] r, output logic e,
                        output int l);
    req_we = we; req_funct3 = f3; req_addr = a; req_wdata = wd; req_valid = 1'b1;
    wait_ready();
    @(posedge clk); #1;
    req_valid = 1'b0;
    wait_resp(l);
    r = resp_rdata;
    e = resp_err;
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    rstn = 1'b0;
    #2;
    n_cmp++; if (req_ready !== 1'b1) begin n_bad++; $display("FAIL rst_req_ready: got %0b want 1", req_ready); end
    n_cmp++; if (resp_valid !== 1'b0) begin n_bad++; $display("FAIL rst_resp_valid: got %0b want 0", resp_valid); end
    n_cmp++; if (resp_rdata !== 32'h0 || resp_err !== 1'b0) begin n_bad++; $display("FAIL rst_resp: got %h/%0b want 0/0", resp_rdata, resp_err); end
    n_cmp++; if ({mem_wren, mem_rden, mem_rwtyp, mem_addr, mem_data} !== '0) begin n_bad++; $display("FAIL rst_mem_pins: got wren=%0b rden=%0b addr=%h want all 0", mem_wren, mem_rden, mem_addr); end
    @(posedge clk); @(posedge clk); #1;
    rstn = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_word();
    do_req(1'b1, 3'b010, 32'h1000, 32'hDEADBEEF, rd, er, lat);
    word_exp = 32'hDEADBEEF;
    n_cmp++; if (er !== 1'b0 || lat != 1) begin n_bad++; $display("FAIL sw: err=%0b lat=%0d want 0/1", er, lat); end
    do_req(1'b0, 3'b010, 32'h1000, 32'h0, rd, er, lat);
    n_cmp++; if (rd !== 32'hDEADBEEF || er !== 1'b0) begin n_bad++; $display("FAIL lw: got %h/%0b want deadbeef/0", rd, er); end
    n_cmp++; if (lat != 2) begin n_bad++; $display("FAIL lw_latency: got %0d want 2", lat); end
  endtask

  task automatic test_subword_loads();
    do_req(1'b0, 3'b000, 32'h1003, 32'h0, rd, er, lat);
    n_cmp++; if (rd !== 32'hFFFFFFDE || er !== 1'b0) begin n_bad++; $display("FAIL lb: got %h want ffffffde", rd); end
    do_req(1'b0, 3'b100, 32'h1003, 32'h0, rd, er, lat);
    n_cmp++; if (rd !== 32'h000000DE) begin n_bad++; $display("FAIL lbu: got %h want 000000de", rd); end
    do_req(1'b0, 3'b001, 32'h1002, 32'h0, rd, er, lat);
    n_cmp++; if (rd !== 32'hFFFFDEAD) begin n_bad++; $display("FAIL lh: got %h want ffffdead", rd); end
    do_req(1'b0, 3'b101, 32'h1000, 32'h0, rd, er, lat);
    n_cmp++; if (rd !== 32'h0000BEEF) begin n_bad++; $display("FAIL lhu: got %h want 0000beef", rd); end
  endtask

  task automatic test_subword_store();
    int exp_lat;
`ifdef LSU_RMW_EN
    exp_lat  = 3;
    word_exp = 32'hDEAD55EF;
`else
    exp_lat  = 1;
    word_exp = 32'h00000055;
`endif
    do_req(1'b1, 3'b000, 32'h1001, 32'h00000055, rd, er, lat);
    n_cmp++; if (lat != exp_lat || er !== 1'b0 || rd !== 32'h0) begin n_bad++; $display("FAIL sb: lat=%0d err=%0b rdata=%h want %0d/0/0", lat, er, rd, exp_lat); end
    do_req(1'b0, 3'b010, 32'h1000, 32'h0, rd, er, lat);
    n_cmp++; if (rd !== word_exp) begin n_bad++; $display("FAIL sb_readback: got %h want %h", rd, word_exp); end
  endtask

  task automatic test_errors();
    int r0, w0;
    r0 = rden_cnt; w0 = wren_cnt;
    do_req(1'b0, 3'b001, 32'h1001, 32'h0, rd, er, lat);
    n_cmp++; if (er !== 1'b1 || rd !== 32'h0 || lat != 0) begin n_bad++; $display("FAIL lh_misaligned: err=%0b rdata=%h lat=%0d want 1/0/0", er, rd, lat); end
    do_req(1'b1, 3'b010, 32'h1002, 32'h12345678, rd, er, lat);
    n_cmp++; if (er !== 1'b1 || rd !== 32'h0 || lat != 0) begin n_bad++; $display("FAIL sw_misaligned: err=%0b rdata=%h lat=%0d want 1/0/0", er, rd, lat); end
    do_req(1'b1, 3'b100, 32'h1000, 32'h000000AA, rd, er, lat);
    n_cmp++; if (er !== 1'b1) begin n_bad++; $display("FAIL store_f3_100: err=%0b want 1", er); end
    do_req(1'b0, 3'b011, 32'h1000, 32'h0, rd, er, lat);
    n_cmp++; if (er !== 1'b1) begin n_bad++; $display("FAIL load_f3_011: err=%0b want 1", er); end
    n_cmp++; if (rden_cnt != r0 || wren_cnt != w0) begin n_bad++; $display("FAIL err_mem_quiet: rden=%0d wren=%0d want 0/0", rden_cnt - r0, wren_cnt - w0); end
    do_req(1'b0, 3'b010, 32'h1000, 32'h0, rd, er, lat);
    n_cmp++; if (rd !== word_exp || er !== 1'b0) begin n_bad++; $display("FAIL err_readback: got %h want %h", rd, word_exp); end
  endtask

  task automatic test_backpressure();
    int l;
    resp_ready = 1'b0;
    req_we = 1'b0; req_funct3 = 3'b010; req_addr = 32'h1000; req_wdata = 32'h0; req_valid = 1'b1;
    wait_ready();
    @(posedge clk); #1;
    req_addr = 32'h1003; req_funct3 = 3'b100;
    wait_resp(l);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      n_cmp++;
      if (resp_valid !== 1'b1 || resp_rdata !== word_exp || resp_err !== 1'b0 || req_ready !== 1'b0) begin
        n_bad++;
        $display("FAIL hold_%0d: valid=%0b rdata=%h err=%0b ready=%0b want 1/%h/0/0", i, resp_valid, resp_rdata, resp_err, req_ready, word_exp);
      end
    end
    resp_ready = 1'b1;
    @(posedge clk); #1;
    n_cmp++; if (req_ready !== 1'b1 || resp_valid !== 1'b0) begin n_bad++; $display("FAIL release: ready=%0b valid=%0b want 1/0", req_ready, resp_valid); end
    @(posedge clk); #1;
    req_valid = 1'b0;
    n_cmp++; if (req_ready !== 1'b0) begin n_bad++; $display("FAIL pending_accept: ready=%0b want 0", req_ready); end
    wait_resp(l);
    n_cmp++; if (resp_rdata !== {24'h0, word_exp[31:24]}) begin n_bad++; $display("FAIL pending_lbu: got %h want %h", resp_rdata, {24'h0, word_exp[31:24]}); end
    @(posedge clk); #1;
  endtask

  task automatic test_reset_mid_store();
    int w0;
    w0 = wren_cnt;
    req_we = 1'b1; req_funct3 = 3'b000; req_addr = 32'h1002; req_wdata = 32'h000000AA; req_valid = 1'b1;
    wait_ready();
    @(posedge clk); #1;
    req_valid = 1'b0;
    rstn = 1'b0;
    #1;
    n_cmp++; if (mem_wren !== 1'b0 || mem_rden !== 1'b0 || mem_addr !== 32'h0) begin n_bad++; $display("FAIL async_rst_mem: wren=%0b rden=%0b addr=%h want 0", mem_wren, mem_rden, mem_addr); end
    n_cmp++; if (req_ready !== 1'b1 || resp_valid !== 1'b0 || resp_rdata !== 32'h0 || resp_err !== 1'b0) begin n_bad++; $display("FAIL async_rst_resp: ready=%0b valid=%0b rdata=%h err=%0b want 1/0/0/0", req_ready, resp_valid, resp_rdata, resp_err); end
    @(posedge clk); #1;
    rstn = 1'b1;
    @(posedge clk); #1;
    n_cmp++; if (req_ready !== 1'b1 || wren_cnt != w0) begin n_bad++; $display("FAIL post_rst: ready=%0b wren_pulses=%0d want 1/0", req_ready, wren_cnt - w0); end
    do_req(1'b0, 3'b010, 32'h1000, 32'h0, rd, er, lat);
    n_cmp++; if (rd !== word_exp) begin n_bad++; $display("FAIL post_rst_word: got %h want %h", rd, word_exp); end
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 32'h0;
    mem_q      = 32'h0;
    req_valid  = 1'b0;
    req_we     = 1'b0;
    req_funct3 = 3'b000;
    req_addr   = 32'h0;
    req_wdata  = 32'h0;
    resp_ready = 1'b1;
    word_exp   = 32'h0;
    test_reset();
    test_word();
    test_subword_loads();
    test_subword_store();
    test_errors();
    test_backpressure();
    test_reset_mid_store();
    n_cmp++; if (both_cnt != 0) begin n_bad++; $display("FAIL rden_wren_overlap: got %0d cycles want 0", both_cnt); end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1);
  end

endmodule
